// File: rtl/irq_pkg.sv
// Shared types and helpers for the prioritised interrupt controller.
package irq_pkg;

  localparam int MAX_IRQ    = 32;
  localparam int VEC_STRIDE = 4;

  typedef enum logic {ST_IDLE, ST_REQ} irq_state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] idx;
  } lsb_t;

  // Lowest set bit wins: index 0 is the highest priority.
  function automatic lsb_t lowest_set(input logic [MAX_IRQ-1:0] v);
    lsb_t r;
    r = '0;
    for (int i = MAX_IRQ-1; i >= 0; i--) begin
      if (v[i]) begin
        r.vld = 1'b1;
        r.idx = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Core/peripheral side of the interrupt controller; master is the controller.
interface irq_controller_if #(
  parameter int NUM_IRQ   = 8,
  parameter int IRQ_NUM_W = $clog2(NUM_IRQ)
);
  logic [NUM_IRQ-1:0]   irq_lines_i;
  logic                 global_en_i;
  logic                 mask_we_i;
  logic [NUM_IRQ-1:0]   mask_i;
  logic                 irq_ack_i;
  logic                 eoi_i;
  logic                 irq_o;
  logic [IRQ_NUM_W-1:0] irq_num_o;
  logic [31:0]          irq_vec_addr_o;
  logic [NUM_IRQ-1:0]   pending_o;
  logic [NUM_IRQ-1:0]   in_service_o;
  logic [NUM_IRQ-1:0]   mask_o;

  modport master (
    input  irq_lines_i, global_en_i, mask_we_i, mask_i, irq_ack_i, eoi_i,
    output irq_o, irq_num_o, irq_vec_addr_o, pending_o, in_service_o, mask_o
  );

  modport slave (
    output irq_lines_i, global_en_i, mask_we_i, mask_i, irq_ack_i, eoi_i,
    input  irq_o, irq_num_o, irq_vec_addr_o, pending_o, in_service_o, mask_o
  );
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt line: synchroniser chain plus edge- or level-sensitive pending bit.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic line_i,
  input  logic clr_i,
  output logic pend_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= synced;
      // A fresh edge beats a coincident ack so the new event is not lost.
      if (EDGE) pend_o <= (synced & ~prev_q) | (pend_o & ~clr_i);
      else      pend_o <= synced;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Prioritised, maskable interrupt controller with registered req/ack/EOI handshake.
module irq_controller
  import irq_pkg::*;
#(
  parameter int               NUM_IRQ      = 8,
  parameter int               IRQ_NUM_W    = $clog2(NUM_IRQ),
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = {NUM_IRQ{1'b1}},
  parameter int               SYNC_STAGES  = 2,
  parameter bit               NESTING      = 1'b0,
  parameter logic [31:0]      IRQ_VEC_ADDR = 32'h0000_0010
) (
  input  logic              clk,
  input  logic              reset_ni,
  irq_controller_if.master  bus
);

  irq_state_e           state_q;
  logic                 irq_q;
  logic [IRQ_NUM_W-1:0] num_q;
  logic [NUM_IRQ-1:0]   mask_q, isv_q, pend, cand, num_oh, ack_clr, eoi_oh;
  lsb_t                 win, isv_low;
  logic                 ack, eligible;

  assign ack     = (state_q == ST_REQ) && bus.irq_ack_i;
  assign num_oh  = NUM_IRQ'(1) << num_q;
  assign ack_clr = ack ? num_oh : '0;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_MASK[i])
    ) u_cell (
      .clk      (clk),
      .reset_ni (reset_ni),
      .line_i   (bus.irq_lines_i[i]),
      .clr_i    (ack_clr[i]),
      .pend_o   (pend[i])
    );
  end

  assign cand    = pend & mask_q & ~isv_q;
  assign win     = lowest_set(MAX_IRQ'(cand));
  assign isv_low = lowest_set(MAX_IRQ'(isv_q));
  assign eoi_oh  = (bus.eoi_i && isv_low.vld) ? (NUM_IRQ'(1) << isv_low.idx) : '0;

  // Nesting only admits a winner strictly above the highest-priority line in service.
  always_comb begin
    eligible = win.vld && bus.global_en_i;
    if (NESTING) eligible = eligible && (!isv_low.vld || (win.idx < isv_low.idx));
    else         eligible = eligible && !isv_low.vld;
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      mask_q <= '0;
      isv_q  <= '0;
    end else begin
      if (bus.mask_we_i) mask_q <= bus.mask_i;
      // EOI retires first, then a same-cycle ack marks the new line.
      isv_q <= (isv_q & ~eoi_oh) | ack_clr;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      num_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (eligible) begin
          state_q <= ST_REQ;
          irq_q   <= 1'b1;
          num_q   <= IRQ_NUM_W'(win.idx);
        end
        ST_REQ: if (bus.irq_ack_i) begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_o          = irq_q;
  assign bus.irq_num_o      = num_q;
  assign bus.irq_vec_addr_o = IRQ_VEC_ADDR + 32'(num_q) * 32'(VEC_STRIDE);
  assign bus.pending_o      = pend;
  assign bus.in_service_o   = isv_q;
  assign bus.mask_o         = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Two controllers (plain/level-on-line-0 and nesting) under shared stimulus vs a behavioural model.
module tb_irq_controller;

  localparam logic [7:0] EDGE_A = 8'hFE;
  localparam logic [7:0] EDGE_B = 8'hFF;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] lines = '0, mask_in = '0;
  logic gen = 1'b1, mask_we = 1'b0, ack = 1'b0, eoi = 1'b0;
  int ntests = 0, nfail = 0;
  bit cmp_on = 1'b0;

  irq_controller_if #(.NUM_IRQ(8)) ifa ();
  irq_controller_if #(.NUM_IRQ(8)) ifb ();

  irq_controller #(.NUM_IRQ(8), .EDGE_MASK(EDGE_A), .NESTING(1'b0)) u_a (
    .clk(clk), .reset_ni(rst_n), .bus(ifa.master));
  irq_controller #(.NUM_IRQ(8), .EDGE_MASK(EDGE_B), .NESTING(1'b1)) u_b (
    .clk(clk), .reset_ni(rst_n), .bus(ifb.master));

  assign ifa.irq_lines_i = lines;   assign ifb.irq_lines_i = lines;
  assign ifa.global_en_i = gen;     assign ifb.global_en_i = gen;
  assign ifa.mask_we_i   = mask_we; assign ifb.mask_we_i   = mask_we;
  assign ifa.mask_i      = mask_in; assign ifb.mask_i      = mask_in;
  assign ifa.irq_ack_i   = ack;     assign ifb.irq_ack_i   = ack;
  assign ifa.eoi_i       = eoi;     assign ifb.eoi_i       = eoi;

  logic       irq_w[2];
  logic [2:0] num_w[2];
  logic [31:0] vec_w[2];
  logic [7:0] pend_w[2], isv_w[2], mask_w[2];
  assign irq_w[0] = ifa.irq_o;        assign irq_w[1] = ifb.irq_o;
  assign num_w[0] = ifa.irq_num_o;    assign num_w[1] = ifb.irq_num_o;
  assign vec_w[0] = ifa.irq_vec_addr_o; assign vec_w[1] = ifb.irq_vec_addr_o;
  assign pend_w[0] = ifa.pending_o;   assign pend_w[1] = ifb.pending_o;
  assign isv_w[0] = ifa.in_service_o; assign isv_w[1] = ifb.in_service_o;
  assign mask_w[0] = ifa.mask_o;      assign mask_w[1] = ifb.mask_o;

  // h0..h2: raw line samples from the last three edges (2-deep synchroniser + previous).
  typedef struct packed {
    bit       req;
    bit [2:0] num;
    bit [7:0] pend, isv, mask, h0, h1, h2;
  } mstate_t;

  mstate_t m[2];

  function automatic mstate_t step(mstate_t s, int d, logic [7:0] ln, logic ge,
                                   logic mwe, logic [7:0] mi, logic ak, logic eo);
    mstate_t n = s;
    logic [7:0] edges = (d == 0) ? EDGE_A : EDGE_B;
    bit ackv = s.req && ak;
    bit done = 1'b0;
    int w = -1, lo = 8;
    for (int i = 0; i < 8; i++) begin
      if (edges[i]) n.pend[i] = (s.h1[i] & ~s.h2[i]) | (s.pend[i] & ~(ackv && s.num == 3'(i)));
      else          n.pend[i] = s.h1[i];
    end
    for (int i = 0; i < 8; i++)
      if (eo && !done && s.isv[i]) begin n.isv[i] = 1'b0; done = 1'b1; end
    if (ackv) n.isv[s.num] = 1'b1;
    if (mwe) n.mask = mi;
    if (s.req) begin
      if (ak) n.req = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (w < 0 && s.pend[i] && s.mask[i] && !s.isv[i]) w = i;
      for (int i = 0; i < 8; i++)
        if (lo == 8 && s.isv[i]) lo = i;
      if (w >= 0 && ge && ((d == 1) ? (w < lo) : (lo == 8))) begin
        n.req = 1'b1;
        n.num = 3'(w);
      end
    end
    n.h2 = s.h1; n.h1 = s.h0; n.h0 = ln;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= step(m[0], 0, lines, gen, mask_we, mask_in, ack, eoi);
      m[1] <= step(m[1], 1, lines, gen, mask_we, mask_in, ack, eoi);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d irq_o", d),   32'(irq_w[d]),  32'(m[d].req));
        chk($sformatf("dut%0d irq_num", d), 32'(num_w[d]),  32'(m[d].num));
        chk($sformatf("dut%0d vec", d),     vec_w[d],       32'h10 + 32'(m[d].num) * 32'd4);
        chk($sformatf("dut%0d pending", d), 32'(pend_w[d]), 32'(m[d].pend));
        chk($sformatf("dut%0d in_svc", d),  32'(isv_w[d]),  32'(m[d].isv));
        chk($sformatf("dut%0d mask", d),    32'(mask_w[d]), 32'(m[d].mask));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_lines(input logic [7:0] v);
    lines = v; tick(1); lines = '0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(1); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(1); eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_we = 1'b1; mask_in = v; tick(1); mask_we = 1'b0;
  endtask

  task automatic wait_irq(input int d, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      if (irq_w[d]) ok = 1'b1;
      else tick(1);
    end
    ntests++;
    if (!ok) begin
      nfail++;
      $display("FAIL dut%0d wait_irq: irq_o=0 after %0d cycles, required 1", d, maxc);
    end
  endtask

  task automatic drain();
    lines = '0; gen = 1'b1;
    ack = 1'b1; eoi = 1'b1; tick(30);
    ack = 1'b0; tick(10);
    eoi = 1'b0; tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    cmp_on = 1'b1;
    chk("reset irq_o", 32'(irq_w[0]), 32'd0);
    chk("reset vec",   vec_w[0],      32'h10);
    chk("reset mask",  32'(mask_w[1]), 32'd0);
    rst_n = 1'b1;
    write_mask(8'hFF);
    tick(4);

    // Single edge on line 3: request on the 4th edge after the first high sample.
    lines = 8'h08; tick(1); lines = '0;
    tick(2);
    chk("single early irq", 32'(irq_w[0]), 32'd0);
    tick(1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("single dut%0d irq", d), 32'(irq_w[d]), 32'd1);
      chk($sformatf("single dut%0d num", d), 32'(num_w[d]), 32'd3);
      chk($sformatf("single dut%0d vec", d), vec_w[d],      32'h1C);
    end
    pulse_ack();
    chk("single pend3",  32'(pend_w[0][3]), 32'd0);
    chk("single in_svc", 32'(isv_w[0]),     32'h08);
    pulse_eoi();
    chk("single eoi", 32'(isv_w[0]), 32'h00);
    tick(2);

    // Priority: 5 and 2 together, 2 first then 5.
    pulse_lines(8'h24);
    wait_irq(0, 10);
    chk("prio first", 32'(num_w[0]), 32'd2);
    pulse_ack(); tick(2);
    chk("prio blocked", 32'(irq_w[0]), 32'd0);
    pulse_eoi();
    wait_irq(0, 6);
    chk("prio second", 32'(num_w[0]), 32'd5);
    pulse_ack(); pulse_eoi(); tick(2);

    // Nesting on dut1: line 1 preempts 4, line 6 waits.
    pulse_lines(8'h10);
    wait_irq(1, 10);
    pulse_ack();
    pulse_lines(8'h02);
    wait_irq(1, 10);
    chk("nest num",    32'(num_w[1]), 32'd1);
    chk("nest in_svc", 32'(isv_w[1]), 32'h10);
    chk("nonest idle", 32'(irq_w[0]), 32'd0);
    pulse_ack(); pulse_eoi();
    pulse_lines(8'h40);
    tick(8);
    chk("nest low blocked", 32'(irq_w[1]), 32'd0);
    pulse_eoi();
    wait_irq(1, 10);
    chk("nest after eoi", 32'(num_w[1]), 32'd6);
    drain();

    // Level line 0 on dut0 re-requests; edge line 0 on dut1 does not.
    lines = 8'h01;
    wait_irq(0, 10);
    pulse_ack();
    chk("level pend kept", 32'(pend_w[0][0]), 32'd1);
    chk("edge pend clr",   32'(pend_w[1][0]), 32'd0);
    pulse_eoi();
    wait_irq(0, 6);
    chk("level rereq", 32'(num_w[0]), 32'd0);
    chk("edge once",   32'(irq_w[1]), 32'd0);
    drain();

    // Edge line 1 held high requests only once.
    lines = 8'h02;
    wait_irq(0, 10);
    pulse_ack(); pulse_eoi(); tick(8);
    chk("held edge dut0", 32'(irq_w[0]), 32'd0);
    chk("held edge dut1", 32'(irq_w[1]), 32'd0);
    drain();

    // Request held stable across global_en and mask changes.
    pulse_lines(8'h40);
    wait_irq(0, 10);
    gen = 1'b0; write_mask(8'h00); tick(3);
    chk("stable irq",  32'(irq_w[0]),  32'd1);
    chk("stable num",  32'(num_w[0]),  32'd6);
    chk("stable mask", 32'(mask_w[0]), 32'd0);
    pulse_ack();
    chk("stable ack", 32'(irq_w[0]), 32'd0);
    gen = 1'b1; write_mask(8'hFF); pulse_eoi(); drain();

    // Async reset mid-request.
    pulse_lines(8'h08);
    wait_irq(0, 10);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst dut%0d irq", d),  32'(irq_w[d]),  32'd0);
      chk($sformatf("arst dut%0d num", d),  32'(num_w[d]),  32'd0);
      chk($sformatf("arst dut%0d vec", d),  vec_w[d],       32'h10);
      chk($sformatf("arst dut%0d pend", d), 32'(pend_w[d]), 32'd0);
      chk($sformatf("arst dut%0d isv", d),  32'(isv_w[d]),  32'd0);
    end
    tick(1); rst_n = 1'b1;
    write_mask(8'hFF); tick(10);
    chk("post reset quiet", 32'(irq_w[0] | irq_w[1]), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) lines[$urandom_range(0, 7)] ^= 1'b1;
      gen     = ($urandom_range(0, 9) != 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 8'($urandom | $urandom);
      ack     = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 4) == 0);
      tick(1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt controller that feeds the RISC-V core's decoder. It replaces the single `irq`/1-bit `irq_num` pair with NUM_IRQ prioritised, maskable lines.
- Each line is individually configurable as edge- or level-sensitive.
- Provides an optional nesting mode and a registered request/acknowledge/EOI handshake.
- Sits between SoC peripherals and the core; the core acks when the decoder takes the trap and signals EOI on MRET.

Parameters:
- NUM_IRQ, 8, number of interrupt lines (2..32).
- IRQ_NUM_W, $clog2(NUM_IRQ), width of interrupt number.
- EDGE_MASK, {NUM_IRQ{1'b1}}, per-line sensitivity: 1 = rising-edge, 0 = level.
- SYNC_STAGES, 2, synchroniser depth (>=2).
- NESTING, 0, 1 = a higher-priority line may preempt an in-service one.
- IRQ_VEC_ADDR, 32'h00000010, base of the vector table.

Ports:
- clk  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- irq_lines_i  in  NUM_IRQ  raw asynchronous interrupt sources
- global_en_i  in  1  global interrupt enable from core
- mask_we_i  in  1  write strobe for enable mask
- mask_i  in  NUM_IRQ  new enable mask (1 = enabled)
- irq_ack_i  in  1  core accepted the current request
- eoi_i  in  1  core executed MRET
- irq_o  out  1  interrupt request to core
- irq_num_o  out  IRQ_NUM_W  number of the requested interrupt
- irq_vec_addr_o  out  32  IRQ_VEC_ADDR + irq_num_o*4
- pending_o  out  NUM_IRQ  pending bits
- in_service_o  out  NUM_IRQ  in-service bits
- mask_o  out  NUM_IRQ  current enable mask

Behaviour:
- Reset: all flops cleared. irq_o=0, irq_num_o=0, irq_vec_addr_o=IRQ_VEC_ADDR, pending_o=0, in_service_o=0, mask_o=0. Reset is honoured mid-handshake; any outstanding request is dropped.
- Sync: each line passes through SYNC_STAGES flops. An additional flop holds the previous synced value for edge detection.
- Edge line pending:
  - Set on synced 0->1.
  - Cleared on ack of that number.
  - If a set and a clear coincide, set wins; the new edge is kept.
- Level line pending: equals the synced level each cycle. Ack does not clear it.
- Mask: mask_o <= mask_i when mask_we_i. A masked line still records pending but is not a candidate.
- Candidate set is pending & mask & ~in_service. The winner is the lowest index (index 0 = highest priority).
- Eligibility:
  - NESTING=0: requires in_service==0.
  - NESTING=1: winner index must be lower than the lowest set in_service index.
  - In both modes global_en_i=1 is required.
- FSM IDLE/REQ:
  - IDLE: when an eligible winner exists, register irq_num_o, assert irq_o next edge, go to REQ.
  - REQ: irq_o, irq_num_o and irq_vec_addr_o are held stable regardless of line, mask or global_en_i changes.
  - REQ: on irq_ack_i, set in_service[irq_num_o], clear edge pending, deassert irq_o on the same edge, return to IDLE.
  - irq_ack_i in IDLE is ignored.
- Latency: for an enabled edge line with the controller idle, irq_o rises SYNC_STAGES+2 edges after the first edge sampling the line high (synchroniser, pending, request). This is 4 edges by default.
- EOI:
  - Clears the lowest-index set in_service bit. EOI with in_service==0 is ignored.
  - EOI and ack in the same cycle: EOI clears first, then ack sets.
  - A new request may be raised in the cycle after EOI. There is no back-to-back IDLE bubble beyond the pending-to-request registration.
- Vector address: 32-bit modular add, computed combinationally from registered irq_num_o.

Decomposition:
- Package irq_pkg holds:
  - the IDLE/REQ state enum;
  - a function returning the lowest-set-bit index and valid flag for a NUM_IRQ vector;
  - the vector stride constant (4).
- One sub-module, irq_sync_edge: the per-line synchroniser plus edge/level pending cell, instantiated NUM_IRQ times via generate.

Test Plan:
- Single edge: mask=8'hFF, global_en=1, pulse line 3 for 1 cycle → irq_o=1 at 4th edge, irq_num_o=3, irq_vec_addr_o=32'h1C. Ack → pending_o[3]=0, in_service_o=8'h08. EOI → in_service_o=0.
- Priority: lines 5 and 2 rise together (NESTING=0) → request 2 first. After ack and EOI, request 5.
- Nesting (NESTING=1): service line 4 in progress, raise line 1 → irq_num_o=1 while in_service_o=8'h10. Raise line 6 instead → no request until EOI.
- Level vs edge (EDGE_MASK=8'hFE): hold line 0 high through ack and EOI → re-requested. Hold edge line 1 high → requested once only.
- Stability: in REQ, drop global_en_i and write mask=0 → irq_o and irq_num_o unchanged until ack.
- Async reset asserted in REQ → all outputs at reset values immediately. After release, no request until a new edge.
